// File: rtl/fb_pixel_fetch_if.sv
// Framebuffer read port between fb_pixel_fetch and the frame store.
// Address and bank go out, the 2-bit pixel index comes back.
interface fb_pixel_fetch_if;
  logic [14:0] fb_addr_out;
  logic        fb_bank_out;
  logic [1:0]  fb_data_in;

  modport master (
    output fb_addr_out,
    output fb_bank_out,
    input  fb_data_in
  );

  modport slave (
    input  fb_addr_out,
    input  fb_bank_out,
    output fb_data_in
  );
endinterface

// File: rtl/fb_pixel_fetch.sv
// Scales the 160x144 2-bit framebuffer x5 into the 720p raster,
// fetching pixels from BRAM and mapping them through a palette.
module fb_pixel_fetch #(
  parameter int          ACTIVE_H_PIXELS = 1280,
  parameter int          ACTIVE_LINES    = 720,
  parameter int          SRC_WIDTH       = 160,
  parameter int          SRC_HEIGHT      = 144,
  parameter int          SCALE           = 5,
  parameter int          H_OFFSET        = 240,
  parameter int          V_OFFSET        = 0,
  parameter int          BRAM_LATENCY    = 2,
  parameter logic [23:0] BORDER_COLOR    = 24'h000000
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              ad_in,
  input  logic              nf_in,
  input  logic              swap_req_in,
  input  logic              pal_we_in,
  input  logic [1:0]        pal_idx_in,
  input  logic [23:0]       pal_data_in,
  fb_pixel_fetch_if.master  fb,
  output logic [23:0]       rgb_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              ad_out,
  output logic              swap_done_out
);

  localparam int H_RAW = H_OFFSET + SRC_WIDTH * SCALE;
  localparam int H_END =
    (H_RAW > ACTIVE_H_PIXELS) ? ACTIVE_H_PIXELS : H_RAW;
  localparam int V_RAW = V_OFFSET + SRC_HEIGHT * SCALE;
  localparam int V_END =
    (V_RAW > ACTIVE_LINES) ? ACTIVE_LINES : V_RAW;

  localparam logic [10:0] H_LO   = 11'(H_OFFSET);
  localparam logic [10:0] H_SPAN = 11'(H_END - H_OFFSET);
  localparam logic [9:0]  V_LO   = 10'(V_OFFSET);
  localparam logic [9:0]  V_SPAN = 10'(V_END - V_OFFSET);

  localparam int XW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [XW-1:0] SUB_MAX  = XW'(SCALE - 1);
  localparam logic [XW-1:0] SUB_ONE  = XW'(1);
  localparam logic [14:0]   ROW_STEP = 15'(SRC_WIDTH);

  localparam int D = BRAM_LATENCY + 1;

  logic [10:0]   h_rel;
  logic [9:0]    v_rel;
  logic          in_win;
  logic          line_end;
  logic          line_start;
  logic          frame_start;

  logic [XW-1:0] x_sub;
  logic [XW-1:0] y_sub;
  logic [7:0]    src_x;
  logic [7:0]    src_y;
  logic [14:0]   row_base;
  logic [14:0]   addr;

  logic [D-1:0]  win_p;
  logic [D-1:0]  ad_p;
  logic [D-1:0]  hs_p;
  logic [D-1:0]  vs_p;

  logic [23:0]   pal [4];

  logic          bank;
  logic          pending;

  // Offset-relative compares: one unsigned test covers both bounds.
  assign h_rel       = hcount_in - H_LO;
  assign v_rel       = vcount_in - V_LO;
  assign in_win      = ad_in && (h_rel < H_SPAN) && (v_rel < V_SPAN);
  assign line_end    = in_win && (h_rel == H_SPAN - 11'd1);
  assign line_start  = (hcount_in == 11'd0);
  assign frame_start = line_start && (vcount_in == 10'd0);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      x_sub    <= '0;
      src_x    <= '0;
      y_sub    <= '0;
      src_y    <= '0;
      row_base <= '0;
      addr     <= '0;
    end else begin
      if (line_start) begin
        x_sub <= '0;
        src_x <= '0;
      end else if (in_win) begin
        if (x_sub == SUB_MAX) begin
          x_sub <= '0;
          src_x <= src_x + 8'd1;
        end else begin
          x_sub <= x_sub + SUB_ONE;
        end
      end

      if (frame_start) begin
        y_sub    <= '0;
        src_y    <= '0;
        row_base <= '0;
      end else if (line_end) begin
        if (y_sub == SUB_MAX) begin
          y_sub    <= '0;
          src_y    <= src_y + 8'd1;
          row_base <= row_base + ROW_STEP;
        end else begin
          y_sub <= y_sub + SUB_ONE;
        end
      end

      if (in_win)
        addr <= row_base + {7'd0, src_x};
    end
  end

  // Sideband delay matches address register + BRAM + palette register.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      win_p   <= '0;
      ad_p    <= '0;
      hs_p    <= '0;
      vs_p    <= '0;
      rgb_out <= '0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
      ad_out  <= 1'b0;
    end else begin
      win_p  <= {win_p[D-2:0], in_win};
      ad_p   <= {ad_p[D-2:0], ad_in};
      hs_p   <= {hs_p[D-2:0], hs_in};
      vs_p   <= {vs_p[D-2:0], vs_in};
      hs_out <= hs_p[D-1];
      vs_out <= vs_p[D-1];
      ad_out <= ad_p[D-1];
      if (win_p[D-1])
        rgb_out <= pal[fb.fb_data_in];
      else if (ad_p[D-1])
        rgb_out <= BORDER_COLOR;
      else
        rgb_out <= '0;
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      pal[0] <= 24'hE0F8D0;
      pal[1] <= 24'h88C070;
      pal[2] <= 24'h346856;
      pal[3] <= 24'h081820;
    end else if (pal_we_in) begin
      pal[pal_idx_in] <= pal_data_in;
    end
  end

  // A request arriving with nf_in is honoured at that same boundary.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      bank          <= 1'b0;
      pending       <= 1'b0;
      swap_done_out <= 1'b0;
    end else begin
      swap_done_out <= 1'b0;
      if (nf_in && (pending || swap_req_in)) begin
        bank          <= ~bank;
        pending       <= 1'b0;
        swap_done_out <= 1'b1;
      end else if (swap_req_in) begin
        pending <= 1'b1;
      end
    end
  end

  assign fb.fb_addr_out = addr;
  assign fb.fb_bank_out = bank;

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Randomised bench for fb_pixel_fetch against an arithmetic raster model.
// Frames are shortened vertically so several fit in the cycle budget.
module tb_fb_pixel_fetch;

  localparam int HO   = 240;
  localparam int VO   = 0;
  localparam int SW   = 160;
  localparam int SH   = 2;
  localparam int SC   = 5;
  localparam int AL   = SH * SC;
  localparam int MAXA = SW * SH - 1;
  localparam int NMAX = 70000;
  localparam logic [23:0] BORDER = 24'h000000;

  typedef struct {
    bit        rst;
    int        h;
    int        v;
    bit        hs;
    bit        vs;
    bit        ad;
    bit        nf;
    bit        swap;
    bit        we;
    bit [1:0]  idx;
    bit [23:0] data;
    int        fr;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic        ad_in = 1'b0;
  logic        nf_in = 1'b0;
  logic        swap_req_in = 1'b0;
  logic        pal_we_in = 1'b0;
  logic [1:0]  pal_idx_in = '0;
  logic [23:0] pal_data_in = '0;
  logic [23:0] rgb_out;
  logic        hs_out;
  logic        vs_out;
  logic        ad_out;
  logic        swap_done_out;

  fb_pixel_fetch_if fb_bus ();

  fb_pixel_fetch #(
    .ACTIVE_LINES (AL),
    .SRC_HEIGHT   (SH)
  ) dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .hs_in         (hs_in),
    .vs_in         (vs_in),
    .ad_in         (ad_in),
    .nf_in         (nf_in),
    .swap_req_in   (swap_req_in),
    .pal_we_in     (pal_we_in),
    .pal_idx_in    (pal_idx_in),
    .pal_data_in   (pal_data_in),
    .fb            (fb_bus.master),
    .rgb_out       (rgb_out),
    .hs_out        (hs_out),
    .vs_out        (vs_out),
    .ad_out        (ad_out),
    .swap_done_out (swap_done_out)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] memf(input logic [14:0] a,
                                      input bit b);
    logic [1:0] lo;
    lo = a[1:0];
    return b ? ~lo : lo;
  endfunction

  // Two-stage BRAM: each bank holds a different pattern.
  logic [1:0] d1, d2;
  always_ff @(posedge clk) begin
    d1 <= memf(fb_bus.fb_addr_out, fb_bus.fb_bank_out);
    d2 <= d1;
  end
  assign fb_bus.fb_data_in = d2;

  stim_t       S [NMAX];
  logic [14:0] ahist [NMAX];
  bit          khist [NMAX];
  bit          bhist [NMAX];
  int          kd = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic bit in_win(input stim_t s);
    return s.ad && s.h >= HO && s.h < HO + SW * SC &&
           s.v >= VO && s.v < VO + SH * SC;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h, expected %h",
               nm, kd, act, exp);
    end
  endtask

  function automatic stim_t mk(input int fr, input int v,
                               input int h, input bit rst);
    stim_t s;
    s.rst  = rst;
    s.h    = h;
    s.v    = v;
    s.ad   = (h < 1280) && (v < AL);
    s.hs   = (h >= 1281) && (h <= 1283);
    s.vs   = (v == AL + 1);
    s.nf   = (v == AL) && (h == 0);
    s.swap = 1'b0;
    s.we   = 1'b0;
    s.idx  = '0;
    s.data = '0;
    s.fr   = fr;
    return s;
  endfunction

  task automatic apply(input stim_t st);
    kd++;
    if (kd >= NMAX) begin
      $display("FAIL stimulus_overflow: edge %0d, limit %0d", kd, NMAX);
      $fatal(1);
    end
    S[kd]       = st;
    rst_in      = st.rst;
    hcount_in   = 11'(st.h);
    vcount_in   = 10'(st.v);
    hs_in       = st.hs;
    vs_in       = st.vs;
    ad_in       = st.ad;
    nf_in       = st.nf;
    swap_req_in = st.swap;
    pal_we_in   = st.we;
    pal_idx_in  = st.idx;
    pal_data_in = st.data;
  endtask

  task automatic step(input stim_t st);
    @(negedge clk);
    #1;
    apply(st);
  endtask

  initial begin : drive
    int lo [3];
    int hi [3];
    stim_t st;
    lo = '{0, 236, 1276};
    hi = '{3, 1043, 1284};
    apply(mk(0, AL + 1, 1282, 1'b1));
    repeat (3) step(mk(0, AL + 1, 1282, 1'b1));
    for (int fr = 0; fr < 6; fr++) begin
      for (int v = 0; v < AL + 2; v++) begin
        for (int g = 0; g < 3; g++) begin
          for (int h = lo[g]; h <= hi[g]; h++) begin
            st = mk(fr, v, h,
                    fr == 4 && v == 7 && h >= 600 && h <= 602);
            st.swap = (fr == 1 && h == 300 && v >= 4 && v <= 6) ||
                      (fr == 3 && st.nf) ||
                      (fr == 4 && v == 5 && h == 300) ||
                      (fr == 5 && $urandom_range(0, 1999) == 0);
            if (fr == 1 && v == 3 && h == 500) begin
              st.we   = 1'b1;
              st.idx  = 2'd3;
              st.data = 24'hFF0000;
            end else if (fr >= 4 && $urandom_range(0, 199) == 0) begin
              st.we   = 1'b1;
              st.idx  = 2'($urandom_range(0, 3));
              st.data = 24'($urandom);
            end
            step(st);
          end
        end
      end
    end
    repeat (8) step(mk(6, AL + 1, 1282, 1'b0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin : compare
    logic [23:0] mpal [4];
    logic [14:0] eaddr;
    logic [1:0]  d;
    bit          mbank, mpend, known, synced, edone, rw;
    stim_t       s, s3, sp;
    int          n;
    mpal  = '{24'hE0F8D0, 24'h88C070, 24'h346856, 24'h081820};
    mbank = 1'b0;
    mpend = 1'b0;
    known = 1'b0;
    synced = 1'b0;
    eaddr = '0;
    forever begin
      @(negedge clk);
      n = kd;
      if (n < 1) continue;
      s = S[n];

      edone = 1'b0;
      if (s.rst) begin
        mbank = 1'b0;
        mpend = 1'b0;
      end else if (s.nf && (mpend || s.swap)) begin
        mbank = !mbank;
        mpend = 1'b0;
        edone = 1'b1;
      end else if (s.swap) begin
        mpend = 1'b1;
      end
      chk("bank", {31'd0, fb_bus.fb_bank_out}, {31'd0, mbank});
      chk("swap_done", {31'd0, swap_done_out}, {31'd0, edone});

      // Address is pixel coordinate / SCALE, known once re-synced.
      if (s.rst) begin
        eaddr  = '0;
        known  = 1'b1;
        synced = 1'b0;
      end else begin
        if (s.v == 0 && s.h == 0) synced = 1'b1;
        if (in_win(s)) begin
          if (synced) begin
            eaddr = 15'(((s.v - VO) / SC) * SW + (s.h - HO) / SC);
            known = 1'b1;
          end else begin
            known = 1'b0;
          end
        end
      end
      if (known)
        chk("fb_addr", {17'd0, fb_bus.fb_addr_out}, {17'd0, eaddr});
      chk("addr_range", {31'd0, fb_bus.fb_addr_out > 15'(MAXA)}, 32'd0);
      ahist[n] = eaddr;
      khist[n] = known;
      bhist[n] = mbank;

      rw = 1'b0;
      for (int m = n - 3; m <= n; m++)
        if (m < 1 || S[m].rst) rw = 1'b1;
      if (rw) begin
        chk("rgb_reset", {8'd0, rgb_out}, 32'd0);
        chk("hs_reset", {31'd0, hs_out}, 32'd0);
        chk("vs_reset", {31'd0, vs_out}, 32'd0);
        chk("ad_reset", {31'd0, ad_out}, 32'd0);
      end else begin
        s3 = S[n-3];
        chk("hs_delay", {31'd0, hs_out}, {31'd0, s3.hs});
        chk("vs_delay", {31'd0, vs_out}, {31'd0, s3.vs});
        chk("ad_delay", {31'd0, ad_out}, {31'd0, s3.ad});
        if (in_win(s3)) begin
          if (khist[n-3]) begin
            d = memf(ahist[n-3], bhist[n-3]);
            chk("rgb_pixel", {8'd0, rgb_out}, {8'd0, mpal[d]});
          end
        end else begin
          chk("rgb_border", {8'd0, rgb_out},
              {8'd0, s3.ad ? BORDER : 24'h0});
        end
        if (s3.fr == 0 && s3.v == 0 && s3.h == 245)
          chk("lit_rgb_245_0", {8'd0, rgb_out}, 32'h0088C070);
        if (s3.fr == 0 && s3.v == 0 && s3.h == 239)
          chk("lit_rgb_239_0", {8'd0, rgb_out}, 32'h00000000);
        if (s3.fr == 1 && s3.v == 8 && s3.h == 255)
          chk("lit_rgb_pal3", {8'd0, rgb_out}, 32'h00FF0000);
        if (s3.fr == 1 && s3.v == 8 && s3.h == 245)
          chk("lit_rgb_pal1", {8'd0, rgb_out}, 32'h0088C070);
      end

      if (!s.rst && s.fr == 0 && s.v == 0 && s.h == 240)
        chk("lit_addr_240_0", {17'd0, fb_bus.fb_addr_out}, 32'd0);
      if (!s.rst && s.fr == 0 && s.v == 0 && s.h == 244)
        chk("lit_addr_244_0", {17'd0, fb_bus.fb_addr_out}, 32'd0);
      if (!s.rst && s.fr == 0 && s.v == 0 && s.h == 245)
        chk("lit_addr_245_0", {17'd0, fb_bus.fb_addr_out}, 32'd1);
      if (!s.rst && s.fr == 0 && s.v == 0 && s.h == 1039)
        chk("lit_addr_1039_0", {17'd0, fb_bus.fb_addr_out}, 32'd159);
      if (!s.rst && s.fr == 0 && s.v == 5 && s.h == 240)
        chk("lit_addr_240_5", {17'd0, fb_bus.fb_addr_out}, 32'd160);
      if (!s.rst && s.fr == 0 && s.v == AL - 1 && s.h == 1039)
        chk("lit_addr_last", {17'd0, fb_bus.fb_addr_out}, 32'(MAXA));
      if (!s.rst && s.fr == 5 && s.v == 0 && s.h == 240)
        chk("lit_addr_restart", {17'd0, fb_bus.fb_addr_out}, 32'd0);

      if (s.nf && s.fr == 1) begin
        chk("lit_bank_first_nf", {31'd0, fb_bus.fb_bank_out}, 32'd1);
        chk("lit_done_first_nf", {31'd0, swap_done_out}, 32'd1);
      end
      if (n > 1) begin
        sp = S[n-1];
        if (sp.nf && sp.fr == 1)
          chk("lit_done_one_cycle", {31'd0, swap_done_out}, 32'd0);
      end
      if (s.nf && s.fr == 2) begin
        chk("lit_bank_no_toggle", {31'd0, fb_bus.fb_bank_out}, 32'd1);
        chk("lit_done_no_toggle", {31'd0, swap_done_out}, 32'd0);
      end
      if (s.nf && s.fr == 3) begin
        chk("lit_bank_same_cycle", {31'd0, fb_bus.fb_bank_out}, 32'd0);
        chk("lit_done_same_cycle", {31'd0, swap_done_out}, 32'd1);
      end
      if (s.rst && s.fr == 4) begin
        chk("lit_rst_bank", {31'd0, fb_bus.fb_bank_out}, 32'd0);
        chk("lit_rst_addr", {17'd0, fb_bus.fb_addr_out}, 32'd0);
        chk("lit_rst_rgb", {8'd0, rgb_out}, 32'd0);
      end
      if (s.nf && s.fr == 4) begin
        chk("lit_rst_pend_bank", {31'd0, fb_bus.fb_bank_out}, 32'd0);
        chk("lit_rst_pend_done", {31'd0, swap_done_out}, 32'd0);
      end

      if (s.rst)
        mpal = '{24'hE0F8D0, 24'h88C070, 24'h346856, 24'h081820};
      else if (s.we)
        mpal[s.idx] = s.data;
    end
  end

endmodule

// File: doc/fb_pixel_fetch.md
Name: fb_pixel_fetch

Overview:
- Sits directly downstream of the video timing generator.
- Consumes its hcount/vcount/hs/vs/ad/nf outputs and produces the emulator's 160x144 2-bit framebuffer image, scaled x5 and centred, as 24-bit RGB in the 1280x720 raster.
- Issues BRAM read addresses, applies a 4-entry palette, and delays sync/active signals to match pixel latency.
- Owns double-buffer bank selection, with swaps only at frame boundaries.

Parameters:
- ACTIVE_H_PIXELS, 1280: active pixels per line.
- ACTIVE_LINES, 720: active lines per frame.
- SRC_WIDTH, 160: source framebuffer width.
- SRC_HEIGHT, 144: source framebuffer height.
- SCALE, 5: integer replication factor in both axes.
- H_OFFSET, 240: first raster column of the image window.
- V_OFFSET, 0: first raster line of the image window.
- BRAM_LATENCY, 2: cycles from fb_addr_out to valid fb_data_in.
- BORDER_COLOR, 24'h000000: RGB output outside the window.

Ports:
- pixel_clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- hcount_in  input  11  horizontal count from the timing generator
- vcount_in  input  10  vertical count from the timing generator
- hs_in  input  1  horizontal sync
- vs_in  input  1  vertical sync
- ad_in  input  1  active-display flag
- nf_in  input  1  single-cycle new-frame pulse
- swap_req_in  input  1  pulse requesting a bank swap at the next nf_in
- pal_we_in  input  1  palette write enable
- pal_idx_in  input  2  palette entry to write
- pal_data_in  input  24  RGB value to write
- fb_addr_out  output  15  framebuffer read address (src_y*SRC_WIDTH + src_x)
- fb_bank_out  output  1  bank being displayed
- fb_data_in  input  2  pixel index returned by BRAM
- rgb_out  output  24  pixel colour
- hs_out  output  1  hs_in delayed by L
- vs_out  output  1  vs_in delayed by L
- ad_out  output  1  ad_in delayed by L
- swap_done_out  output  1  single-cycle pulse when a bank swap takes effect

Behaviour:
- Clock and reset: single clock domain, pixel_clk_in; reset is synchronous, active-high on rst_in.
- Reset values:
  - All outputs are 0.
  - Bank = 0; swap pending = 0.
  - Delay pipes are cleared.
  - Palette resets to 0:24'hE0F8D0, 1:24'h88C070, 2:24'h346856, 3:24'h081820.
  - All internal counters are 0.
- Window membership: a cycle is in-window iff ad_in, H_OFFSET <= hcount_in < H_OFFSET+SRC_WIDTH*SCALE, and V_OFFSET <= vcount_in < V_OFFSET+SRC_HEIGHT*SCALE.
- Address generation: no multipliers or dividers; use incremental counters x_sub, src_x, y_sub, src_y, row_base.
  - Horizontal:
    - hcount_in==0 clears x_sub and src_x.
    - On each in-window cycle, x_sub increments; at x_sub==SCALE-1 it wraps to 0 and src_x increments.
  - Vertical:
    - vcount_in==0 && hcount_in==0 clears y_sub, src_y and row_base.
    - On the last in-window cycle of a line, y_sub increments; at SCALE-1 it wraps, src_y increments, and row_base += SRC_WIDTH.
- fb_addr_out: registered, equal to row_base+src_x for the in-window cycle one cycle earlier. Holds its last value outside the window.
- Latency: L = 1 + BRAM_LATENCY + 1 (4 by default).
  - rgb_out, hs_out, vs_out and ad_out all correspond to the inputs of cycle t-L.
  - In-window flag pipe has the same depth.
- rgb_out:
  - In-window: palette[fb_data_in], registered.
  - Otherwise: BORDER_COLOR if delayed ad, else 0.
- Palette writes: take effect the cycle after pal_we_in. Affect only pixels whose lookup stage occurs after that cycle. Tearing mid-frame is permitted.
- Bank swap:
  - swap_req_in sets pending.
  - On an nf_in cycle with pending (or with swap_req_in in the same cycle): toggle the bank, pulse swap_done_out for exactly 1 cycle (the next cycle), and clear pending.
  - Repeated requests before nf_in collapse into one swap.
  - fb_bank_out changes only on nf_in.
- Reset mid-frame: all state returns to reset values and no swap_done_out is emitted. Counters resynchronise from the next hcount_in==0 / vcount_in==0.
- Widths: src_x is 8 bits, src_y is 8 bits, row_base is 15 bits; max address = 23039. No wrap occurs within legal parameters.

Test Plan:
- Reset, then run 1 full frame -> fb_addr_out at raster (240,0)+1 cycle = 0; at (244,0) = 0; at (245,0) = 1; at (1039,0) = 159; at (240,5) = 160; at (1039,719) = 23039. Never >23039.
- Model BRAM (latency 2) returning addr[1:0] -> rgb_out at raster (245,0)+4 cycles = 24'h88C070; at (239,0)+4 = 24'h000000; ad_out/hs_out/vs_out equal the inputs delayed exactly 4 cycles throughout.
- pal_we_in=1, idx=3, data=24'hFF0000 mid-frame -> later index-3 pixels output 24'hFF0000; other entries unchanged.
- swap_req_in pulsed 3 times mid-frame -> fb_bank_out toggles 0->1 exactly at the first nf_in; swap_done_out high for 1 cycle; no toggle at the following nf_in.
- swap_req_in asserted on the same cycle as nf_in -> swap occurs at that nf_in; swap_done_out pulses the next cycle.
- rst_in asserted for 3 cycles at raster (600,300) with pending swap -> outputs 0, bank 0, pending cleared. Next frame: addresses restart at 0 at (240,0).
